// File: rtl/fetch_pc_if.sv
// fetch_pc_if: fetch-unit bus (stall/redirect in, imem port, decode outputs); FETCH_PERF_CNT_EN adds perf counters.
interface fetch_pc_if #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 32
);
  logic               stall;
  logic               PCSrc;
  logic [PC_W-1:0]    exNPC;
  logic               imemEn;
  logic [PC_W-1:0]    imemAddr;
  logic [INSTR_W-1:0] imemData;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    PC;
  logic               instrValid;
  logic               halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]        fetchCount;
  logic [15:0]        flushCount;
  modport master (input stall, PCSrc, exNPC, imemData,
                  output imemEn, imemAddr, instr, PC, instrValid, halted, fetchCount, flushCount);
  modport slave  (output stall, PCSrc, exNPC, imemData,
                  input imemEn, imemAddr, instr, PC, instrValid, halted, fetchCount, flushCount);
`else
  modport master (input stall, PCSrc, exNPC, imemData,
                  output imemEn, imemAddr, instr, PC, instrValid, halted);
  modport slave  (output stall, PCSrc, exNPC, imemData,
                  input imemEn, imemAddr, instr, PC, instrValid, halted);
`endif
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC sequencer over a 1-cycle sync imem with redirect, stall and HALT; FETCH_PERF_CNT_EN adds counters.
module fetch_pc_unit #(
  parameter int                 PC_W       = 10,
  parameter int                 INSTR_W    = 32,
  parameter logic [PC_W-1:0]    RESET_PC   = '0,
  parameter logic [INSTR_W-1:0] HALT_INSTR = '1
) (
  input logic        clk,
  input logic        rst,
  fetch_pc_if.master bus
);
  typedef enum logic {RUN, HALT} state_t;
  state_t             r_state;
  logic [PC_W-1:0]    r_fetch_pc, r_issued_pc, r_pc;
  logic               r_issued_valid, r_instr_valid;
  logic [INSTR_W-1:0] r_instr;
  logic               w_halt_hit;
  assign w_halt_hit      = r_issued_valid && (bus.imemData == HALT_INSTR);
  assign bus.imemEn      = (r_state == RUN) && rst && !bus.PCSrc && !bus.stall;
  assign bus.imemAddr    = r_fetch_pc;
  assign bus.instr       = r_instr;
  assign bus.PC          = r_pc;
  assign bus.instrValid  = r_instr_valid;
  assign bus.halted      = (r_state == HALT);
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= RUN;
      r_fetch_pc     <= RESET_PC;
      r_issued_pc    <= '0;
      r_issued_valid <= 1'b0;
      r_instr        <= '0;
      r_pc           <= '0;
      r_instr_valid  <= 1'b0;
    end else if (bus.PCSrc) begin
      r_state        <= RUN;
      r_fetch_pc     <= bus.exNPC;
      r_issued_valid <= 1'b0;
      r_instr_valid  <= 1'b0;
    end else if (!bus.stall) begin
      if (r_state == HALT) begin
        r_instr_valid <= 1'b0;
      end else begin
        r_instr        <= bus.imemData;
        r_pc           <= r_issued_pc;
        r_instr_valid  <= r_issued_valid;
        r_issued_pc    <= r_fetch_pc;
        // on HALT the successor read in flight is dropped, so fetchPC parks on it
        r_issued_valid <= !w_halt_hit;
        r_fetch_pc     <= w_halt_hit ? r_fetch_pc : r_fetch_pc + PC_W'(1);
        r_state        <= w_halt_hit ? HALT : RUN;
      end
    end
  end
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_fetch_count, r_flush_count;
  assign bus.fetchCount = r_fetch_count;
  assign bus.flushCount = r_flush_count;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fetch_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (bus.PCSrc && r_flush_count != 16'hFFFF)
        r_flush_count <= r_flush_count + 16'd1;
      if (!bus.PCSrc && !bus.stall && r_state == RUN && r_issued_valid && r_fetch_count != 16'hFFFF)
        r_fetch_count <= r_fetch_count + 16'd1;
    end
  end
`endif
endmodule
